multi_digit_counter_display: RTL

Parametrised successor to the single-digit 1 s counter with hex display. It keeps an N-digit up/down counter that advances once per prescaled tick and supports BCD or hex digits, synchronous load and clear. It drives a time-multiplexed active-low 7-segment display with optional leading-zero blanking. It sits directly under the board top level, fed by the raw board clock.

---
 rtl/multi_digit_counter_display_if.sv | 27 ++
 rtl/multi_digit_counter_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multi_digit_counter_display_if.sv
// Control/status bundle for the multi-digit counter: count controls in, count and
// multiplexed 7-segment drive out.
interface multi_digit_counter_display_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  hex_mode;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  blank_lz;
  logic [4*DIGITS-1:0]   q;
  logic                  Rc;
  logic [6:0]            segment;
  logic [DIGITS-1:0]     AN;

  modport master (
    output en, up, hex_mode, clr, load, load_val, blank_lz,
    input  q, Rc, segment, AN
  );

  modport slave (
    input  en, up, hex_mode, clr, load, load_val, blank_lz,
    output q, Rc, segment, AN
  );
endinterface

// File: rtl/multi_digit_counter_display.sv
// N-digit BCD/hex up/down counter stepped by a prescaled tick, with a registered
// time-multiplexed active-low 7-segment driver and optional leading-zero blanking.

// One digit of the ripple chain. o_sat says whether this digit passes the carry
// (at max going up, at zero going down); o_d is the digit after a step with i_ci.
module mdcd_digit (
  input  logic       i_ci,
  input  logic       i_up,
  input  logic       i_hex,
  input  logic [3:0] i_d,
  output logic       o_sat,
  output logic [3:0] o_d
);
  logic       w_bcd_ovr;
  logic [3:0] w_max;

  // A digit above 9 left over from hex mode behaves like 9 in BCD
  assign w_bcd_ovr = !i_hex && (i_d > 4'h9);
  assign w_max     = i_hex ? 4'hF : 4'h9;
  assign o_sat     = i_up ? ((i_d == w_max) || w_bcd_ovr) : (i_d == 4'h0);

  always_comb begin
    o_d = i_d;
    if (i_ci) begin
      if (i_up)           o_d = o_sat ? 4'h0 : i_d + 4'h1;
      else if (o_sat)     o_d = w_max;
      else if (w_bcd_ovr) o_d = 4'h8;
      else                o_d = i_d - 4'h1;
    end
  end
endmodule

module multi_digit_counter_display #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  multi_digit_counter_display_if.slave      bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_TC  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TC  = IW'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] r_q;
  logic [PW-1:0]          r_pre;
  logic [SW-1:0]          r_scan;
  logic [IW-1:0]          r_idx;
  logic                   r_rc;
  logic [DIGITS-1:0]      r_an;
  logic [6:0]             r_seg;

  logic                   w_tick;
  logic                   w_scan_tc;
  logic [DIGITS-1:0][3:0] w_step;
  logic [DIGITS-1:0][3:0] w_load;
  logic [DIGITS-1:0]      w_sat;
  logic [DIGITS:0]        w_ci;
  logic [DIGITS:0]        w_zabove;
  logic [3:0]             w_dig;
  logic                   w_blank;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'h0: f_seg = 7'h40;  4'h1: f_seg = 7'h79;
      4'h2: f_seg = 7'h24;  4'h3: f_seg = 7'h30;
      4'h4: f_seg = 7'h19;  4'h5: f_seg = 7'h12;
      4'h6: f_seg = 7'h02;  4'h7: f_seg = 7'h78;
      4'h8: f_seg = 7'h00;  4'h9: f_seg = 7'h10;
      4'hA: f_seg = 7'h08;  4'hB: f_seg = 7'h03;
      4'hC: f_seg = 7'h46;  4'hD: f_seg = 7'h21;
      4'hE: f_seg = 7'h06;  default: f_seg = 7'h0E;
    endcase
  endfunction

  assign w_tick    = (r_pre == PRE_TC);
  assign w_scan_tc = (r_scan == SCAN_TC);

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      mdcd_digit u_dig (
        .i_ci  (w_ci[g]),
        .i_up  (bus.up),
        .i_hex (bus.hex_mode),
        .i_d   (r_q[g]),
        .o_sat (w_sat[g]),
        .o_d   (w_step[g])
      );
      assign w_load[g] = (!bus.hex_mode && (bus.load_val[4*g+3:4*g] > 4'h9))
                         ? 4'h0 : bus.load_val[4*g+3:4*g];
    end
  endgenerate

  // Carry into digit k is set when every lower digit saturates; the top carry is the wrap
  always_comb begin
    w_ci[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) w_ci[k+1] = w_ci[k] & w_sat[k];
  end

  always_comb begin
    w_zabove[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) w_zabove[k] = w_zabove[k+1] & (r_q[k] == 4'h0);
  end

  assign w_dig   = r_q[r_idx];
  assign w_blank = bus.blank_lz && (r_idx != '0) && w_zabove[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      r_rc <= 1'b0;
    end else begin
      r_rc <= 1'b0;
      if (bus.clr) begin
        r_q <= '0;
      end else if (bus.load) begin
        r_q <= w_load;
      end else if (w_tick && bus.en) begin
        r_q  <= w_step;
        r_rc <= w_ci[DIGITS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else begin
      r_scan <= w_scan_tc ? '0 : r_scan + 1'b1;
      if (w_scan_tc) r_idx <= (r_idx == IDX_TC) ? '0 : r_idx + 1'b1;
    end
  end

  // Display registers sample the current count, so they trail q by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= w_blank ? 7'h7F : f_seg(w_dig);
    end
  end

  assign bus.q       = r_q;
  assign bus.Rc      = r_rc;
  assign bus.AN      = r_an;
  assign bus.segment = r_seg;
endmodule
